// File: rtl/wb_xbar_pkg.sv
// Shared types and helpers for the Wishbone one-to-N decoder.
// FSM encoding plus elaboration-time and decode helper functions.
package wb_xbar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int MAX_SLAVES = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic logic [3:0] onehot_to_index(input logic [MAX_SLAVES-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_SLAVES; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_xbar_dec_if.sv
// Bundle of the master-side and slave-side Wishbone signals around the decoder.
// 'slave' is the decoder's view (it is the slave of the host); 'master' is the host/peripheral view.
interface wb_xbar_dec_if #(
    parameter int N_SLAVES = 4,
    parameter int AW       = 32,
    parameter int DW       = 32
);
    logic                   m_cyc;
    logic                   m_stb;
    logic                   m_we;
    logic [AW-1:0]          m_adr;
    logic [DW/8-1:0]        m_sel;
    logic [DW-1:0]          m_dat_w;
    logic [DW-1:0]          m_dat_r;
    logic                   m_ack;
    logic                   m_err;
    logic                   m_stall;

    logic [N_SLAVES-1:0]    s_cyc;
    logic [N_SLAVES-1:0]    s_stb;
    logic                   s_we;
    logic [AW-1:0]          s_adr;
    logic [DW/8-1:0]        s_sel;
    logic [DW-1:0]          s_dat_w;
    logic [N_SLAVES*DW-1:0] s_dat_r;
    logic [N_SLAVES-1:0]    s_ack;
    logic [N_SLAVES-1:0]    s_err;

    modport slave (
        input  m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_w, s_dat_r, s_ack, s_err,
        output m_dat_r, m_ack, m_err, m_stall, s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_w
    );

    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_w, s_dat_r, s_ack, s_err,
        input  m_dat_r, m_ack, m_err, m_stall, s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_w
    );

endinterface

// File: rtl/wb_xbar_addr_dec.sv
// Combinational base/mask address decoder; lowest matching index wins, all-zero mask is a catch-all.
// Zero latency; no flow control.
module wb_xbar_addr_dec
    import wb_xbar_pkg::*;
#(
    parameter int                     N_SLAVES   = 4,
    parameter int                     AW         = 32,
    parameter logic [N_SLAVES*AW-1:0] SLAVE_BASE = '0,
    parameter logic [N_SLAVES*AW-1:0] SLAVE_MASK = '0,
    localparam int                    IW         = (clog2(N_SLAVES) > 0) ? clog2(N_SLAVES) : 1
) (
    input  logic [AW-1:0] adr_i,
    output logic          hit_o,
    output logic [IW-1:0] idx_o,
    output logic [AW-1:0] rel_adr_o
);

    logic [N_SLAVES-1:0]   match;
    logic [N_SLAVES-1:0]   lowest;
    logic [MAX_SLAVES-1:0] lowest_pad;

    always_comb begin
        match = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            match[i] = ((adr_i & SLAVE_MASK[i*AW +: AW]) ==
                        (SLAVE_BASE[i*AW +: AW] & SLAVE_MASK[i*AW +: AW]));
        end
    end

    // Isolate the lowest set bit so overlapping windows resolve to the lowest index.
    assign lowest = match & (~match + N_SLAVES'(1));

    always_comb begin
        lowest_pad                 = '0;
        lowest_pad[N_SLAVES-1:0]   = lowest;
    end

    assign hit_o     = |match;
    assign idx_o     = IW'(onehot_to_index(lowest_pad));
    assign rel_adr_o = adr_i & ~SLAVE_MASK[idx_o*AW +: AW];

endmodule

// File: rtl/wb_xbar_dec.sv
// One Wishbone master fanned out to N_SLAVES by address; unmapped -> err, optional timeout, abort on cyc drop.
// Slave strobe 1 cycle after accept, master ack/err 1 cycle after slave response; single outstanding, stall while busy.
module wb_xbar_dec
    import wb_xbar_pkg::*;
#(
    parameter int                     N_SLAVES   = 4,
    parameter int                     AW         = 32,
    parameter int                     DW         = 32,
    parameter logic [N_SLAVES*AW-1:0] SLAVE_BASE = '0,
    parameter logic [N_SLAVES*AW-1:0] SLAVE_MASK = '0,
    parameter int                     TIMEOUT    = 255,
    localparam int                    IW         = (clog2(N_SLAVES) > 0) ? clog2(N_SLAVES) : 1,
    localparam int                    TW         = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1
) (
    input  logic            clk,
    input  logic            rst,
    wb_xbar_dec_if.slave    bus,
    output logic            timeout_o
);

    localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [AW-1:0]     adr_q, adr_d;
    logic [DW/8-1:0]   sel_q, sel_d;
    logic [DW-1:0]     dat_w_q, dat_w_d;
    logic [DW-1:0]     dat_r_q, dat_r_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              err_q, err_d;
    logic [TW-1:0]     timer_q, timer_d;

    logic              dec_hit;
    logic [IW-1:0]     dec_idx;
    logic [AW-1:0]     dec_adr;
    logic              resp_ack;

    wb_xbar_addr_dec #(
        .N_SLAVES   (N_SLAVES),
        .AW         (AW),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_addr_dec (
        .adr_i     (bus.m_adr),
        .hit_o     (dec_hit),
        .idx_o     (dec_idx),
        .rel_adr_o (dec_adr)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        sel_d     = sel_q;
        dat_w_d   = dat_w_q;
        dat_r_d   = dat_r_q;
        idx_d     = idx_q;
        err_d     = err_q;
        timer_d   = timer_q;
        timeout_o = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (bus.m_cyc && bus.m_stb) begin
                    we_d    = bus.m_we;
                    adr_d   = dec_adr;
                    sel_d   = bus.m_sel;
                    dat_w_d = bus.m_dat_w;
                    idx_d   = dec_idx;
                    dat_r_d = '0;
                    err_d   = !dec_hit;
                    state_d = dec_hit ? WAIT : RESP;
                end
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                // Abort outranks any response; err outranks ack; a real response outranks the timeout.
                if (!bus.m_cyc) begin
                    state_d = IDLE;
                end else if (bus.s_err[idx_q]) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    dat_r_d = '0;
                end else if (bus.s_ack[idx_q]) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    dat_r_d = we_q ? '0 : bus.s_dat_r[idx_q*DW +: DW];
                end else if ((TIMEOUT > 0) && (timer_q == TW'(TMO_LAST))) begin
                    state_d   = RESP;
                    err_d     = 1'b1;
                    dat_r_d   = '0;
                    timeout_o = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                timer_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_w_q <= '0;
            dat_r_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_w_q <= dat_w_d;
            dat_r_q <= dat_r_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    assign resp_ack    = (state_q == RESP) && !err_q;
    assign bus.m_ack   = resp_ack;
    assign bus.m_err   = (state_q == RESP) && err_q;
    assign bus.m_stall = (state_q != IDLE);
    assign bus.m_dat_r = resp_ack ? dat_r_q : '0;

    assign bus.s_cyc   = (state_q == WAIT) ? (N_SLAVES'(1) << idx_q) : '0;
    assign bus.s_stb   = (state_q == WAIT) ? (N_SLAVES'(1) << idx_q) : '0;
    assign bus.s_we    = we_q;
    assign bus.s_adr   = adr_q;
    assign bus.s_sel   = sel_q;
    assign bus.s_dat_w = dat_w_q;

endmodule
